tmds_channel_decoder: RTL and testbench
=======================================

// Module: tmds_channel_decoder
// PURPOSE
//  Receive-side TMDS channel: takes 10-bit raw words from an external 1:10 deserializer
//  in the pixclk domain, at an unknown bit offset. Finds word alignment on control-token
//  runs and decodes 10b->8b video data or 2-bit control data plus VDE.
//  One instance per colour channel; blue carries {vSync,hSync} on cd.
// PARAMETERS
//  CTRL_RUN    8     consecutive control tokens at one offset required to declare lock
//  SEARCH_WAIT 1024  words at one offset with no control token before offset advances
//  LOSS_WAIT   2048  words in LOCKED with no control token before lock is dropped
//  DISP_LIMIT  8     |running disparity| (ones-zeros)/2 threshold (TMDS_DISP_MON_EN only)
// PORTS
//  pixclk    in   1   pixel clock (word rate), all logic rising-edge
//  reset_n   in   1   asynchronous, active-low reset
//  din       in   10  raw deserialized word, bit 0 = first bit received
//  vd        out  8   decoded video data
//  cd        out  2   decoded control data {C1,C0}
//  vde       out  1   1 = vd valid (data word), 0 = control period
//  locked    out  1   alignment lock achieved
//  offset    out  4   current alignment bit offset, 0..9
//  disp_err  out  1   disparity out of range (0 when TMDS_DISP_MON_EN undefined)
// BEHAVIOUR
//  Reset: vd=0, cd=0, vde=0, locked=0, offset=0, disp_err=0, FSM=SEARCH, all counters 0.
//  Alignment: win={din,din_prev} (20b); aligned word a=win[offset+9:offset].
//  Tokens: 1101010100->cd=00, 0010101011->01, 0101010100->10, 1010101011->11.
//  Decode of non-token a: d=a[9]?~a[7:0]:a[7:0]; vd[0]=d[0];
//   vd[i]=d[i]^d[i-1] if a[8]=1, else ~(d[i]^d[i-1]), i=1..7.
//  Latency: 2 pixclk; pipeline: reg din_prev + a; reg decode. Latency is fixed, not state-dependent.
//  Outputs: token -> vde=0, cd=token code, vd holds last value; non-token -> vde=1, vd=decoded,
//   cd holds. Outputs are decoded in every state; consumers gate on locked.
//  FSM SEARCH: token at a -> VERIFY, run=1. Else wait++. wait==SEARCH_WAIT-1 ->
//   offset=(offset==9)?0:offset+1, wait=0.
//  FSM VERIFY: token -> run++; run==CTRL_RUN-1 and token -> LOCKED, locked=1 next cycle.
//   Non-token -> run=0, stay VERIFY. Token-timeout counter runs as in SEARCH; on expiry
//   advance offset and go to SEARCH.
//  FSM LOCKED: offset frozen. Each token clears loss counter. Loss counter reaching
//   LOSS_WAIT-1 -> SEARCH, locked=0, offset kept (re-verify at same offset first).
//  Simultaneous: token on the same cycle a counter expires -> token wins, counter clears.
//  Counters saturate-safe: widths sized by $clog2 of their limit.
//  reset_n low mid-operation: immediate return to reset values; no partial decode emitted.
// CONFIGURATION
//  `TMDS_DISP_MON_EN defined: signed 6-bit acc += (popcount(a)-5) on data words;
//   cleared on tokens. disp_err=1, registered, while |acc|>DISP_LIMIT and locked=1;
//   sticky until next token.
//  Undefined: no accumulator, disp_err tied 0.
// STRUCTURE
//  Package tmds_pkg: four control-token constants, FSM state enum {SEARCH,VERIFY,LOCKED},
//   offset width constant; shared with the transmit-side encoder.
//  Sub-module tmds_word_decode: combinational 10b -> {is_token, cd, vd}; instanced once.
// TESTING
//  Encoder model feeds 12 tokens 1101010100 at offset 3 -> locked=1 after 8th token + 2
//   cycles, offset=3.
//  Locked, word for VD=8'hA5 with VDE=1 -> vde=1, vd=8'hA5 exactly 2 cycles later.
//  Random bit slip 0..9 applied: lock acquired within 10*SEARCH_WAIT+CTRL_RUN words,
//   offset equals injected slip.
//  Locked, stream of data-only words for LOSS_WAIT words -> locked=0, state SEARCH,
//   offset unchanged.
//  Token on the cycle the SEARCH timeout expires -> VERIFY entered, offset not advanced.
//  reset_n pulsed low while LOCKED -> all outputs 0 same cycle; relock from offset 0.
//   With TMDS_DISP_MON_EN: 20 words of 8'h00 without inversion -> disp_err=1.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, alignment FSM states and offset sizing.
// Used by both the receive-side channel decoder and the transmit-side encoder.
package tmds_pkg;

   localparam int OFFSET_W   = 4;
   localparam int MAX_OFFSET = 9;

   localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } align_state_t;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS 10b word decoder: flags control tokens and recovers
// either the 2-bit control code or the 8-bit video byte.
module tmds_word_decode (
   input  logic [9:0] word,
   output logic       is_token,
   output logic [1:0] cd,
   output logic [7:0] vd
);
   import tmds_pkg::*;

   logic [7:0] d;

   always_comb begin
      is_token = 1'b1;
      cd       = 2'b00;
      case (word)
         CTRL_TOKEN_00: cd = 2'b00;
         CTRL_TOKEN_01: cd = 2'b01;
         CTRL_TOKEN_10: cd = 2'b10;
         CTRL_TOKEN_11: cd = 2'b11;
         default:       is_token = 1'b0;
      endcase
   end

   // Bit 9 undoes DC-balance inversion, bit 8 selects XOR vs XNOR chaining.
   always_comb begin
      d     = word[9] ? ~word[7:0] : word[7:0];
      vd    = 8'h00;
      vd[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         vd[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
   end

endmodule

// File: rtl/tmds_channel_decoder.sv
// Receive-side TMDS channel: word alignment on control-token runs plus 10b->8b decode.
// Optional running-disparity monitor enabled by defining TMDS_DISP_MON_EN.
module tmds_channel_decoder
   import tmds_pkg::*;
#(
   parameter int CTRL_RUN    = 8,
   parameter int SEARCH_WAIT = 1024,
   parameter int LOSS_WAIT   = 2048,
   parameter int DISP_LIMIT  = 8
) (
   input  logic                pixclk,
   input  logic                reset_n,
   input  logic [9:0]          din,
   output logic [7:0]          vd,
   output logic [1:0]          cd,
   output logic                vde,
   output logic                locked,
   output logic [OFFSET_W-1:0] offset,
   output logic                disp_err
);

   localparam int RUN_W    = (CTRL_RUN > 1) ? $clog2(CTRL_RUN) : 1;
   localparam int SEARCH_W = (SEARCH_WAIT > 1) ? $clog2(SEARCH_WAIT) : 1;
   localparam int LOSS_W   = (LOSS_WAIT > 1) ? $clog2(LOSS_WAIT) : 1;

   logic [9:0]          din_prev;
   logic [19:0]         win;
   logic [9:0]          a;
   logic                prev_valid;
   logic                a_valid;
   logic                tok;
   logic [1:0]          tok_cd;
   logic [7:0]          dec_vd;
   align_state_t        state;
   logic [RUN_W-1:0]    run;
   logic [SEARCH_W-1:0] search_cnt;
   logic [LOSS_W-1:0]   loss_cnt;
   logic [OFFSET_W-1:0] next_offset;

   assign win         = {din, din_prev};
   assign next_offset = (offset == OFFSET_W'(MAX_OFFSET)) ? '0 : offset + 1'b1;

   // The valid flags keep the half-filled window after reset from reaching the outputs.
   always_ff @(posedge pixclk or negedge reset_n) begin
      if (!reset_n) begin
         din_prev   <= '0;
         a          <= '0;
         prev_valid <= 1'b0;
         a_valid    <= 1'b0;
      end else begin
         din_prev   <= din;
         a          <= win[{1'b0, offset} +: 10];
         prev_valid <= 1'b1;
         a_valid    <= prev_valid;
      end
   end

   tmds_word_decode u_word_decode (
      .word     (a),
      .is_token (tok),
      .cd       (tok_cd),
      .vd       (dec_vd)
   );

   always_ff @(posedge pixclk or negedge reset_n) begin
      if (!reset_n) begin
         vd  <= '0;
         cd  <= '0;
         vde <= 1'b0;
      end else if (a_valid) begin
         if (tok) begin
            vde <= 1'b0;
            cd  <= tok_cd;
         end else begin
            vde <= 1'b1;
            vd  <= dec_vd;
         end
      end
   end

   // A token always beats a timeout expiring on the same word.
   always_ff @(posedge pixclk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= SEARCH;
         locked     <= 1'b0;
         offset     <= '0;
         run        <= '0;
         search_cnt <= '0;
         loss_cnt   <= '0;
      end else if (a_valid) begin
         case (state)
            SEARCH: begin
               if (tok) begin
                  state      <= VERIFY;
                  run        <= RUN_W'(1);
                  search_cnt <= '0;
               end else if (search_cnt == SEARCH_W'(SEARCH_WAIT - 1)) begin
                  offset     <= next_offset;
                  search_cnt <= '0;
               end else begin
                  search_cnt <= search_cnt + 1'b1;
               end
            end
            VERIFY: begin
               if (tok) begin
                  search_cnt <= '0;
                  if (run == RUN_W'(CTRL_RUN - 1)) begin
                     state    <= LOCKED;
                     locked   <= 1'b1;
                     run      <= '0;
                     loss_cnt <= '0;
                  end else begin
                     run <= run + 1'b1;
                  end
               end else if (search_cnt == SEARCH_W'(SEARCH_WAIT - 1)) begin
                  state      <= SEARCH;
                  offset     <= next_offset;
                  search_cnt <= '0;
                  run        <= '0;
               end else begin
                  search_cnt <= search_cnt + 1'b1;
                  run        <= '0;
               end
            end
            LOCKED: begin
               if (tok) begin
                  loss_cnt <= '0;
               end else if (loss_cnt == LOSS_W'(LOSS_WAIT - 1)) begin
                  state    <= SEARCH;
                  locked   <= 1'b0;
                  loss_cnt <= '0;
               end else begin
                  loss_cnt <= loss_cnt + 1'b1;
               end
            end
            default: begin
               state  <= SEARCH;
               locked <= 1'b0;
            end
         endcase
      end
   end

`ifdef TMDS_DISP_MON_EN
   logic signed [5:0] disp_acc;
   logic signed [6:0] disp_sum;
   logic signed [5:0] disp_next;
   logic [3:0]        ones;
   logic [5:0]        disp_mag;

   // Accumulator saturates so long unbalanced runs cannot wrap back into range.
   always_comb begin
      ones = '0;
      for (int i = 0; i < 10; i++) begin
         ones = ones + {3'b000, a[i]};
      end
      disp_sum = {disp_acc[5], disp_acc} + $signed({3'b000, ones}) - 7'sd5;
      if (disp_sum > 7'sd31) begin
         disp_next = 6'sd31;
      end else if (disp_sum < -7'sd32) begin
         disp_next = -6'sd32;
      end else begin
         disp_next = disp_sum[5:0];
      end
      disp_mag = disp_acc[5] ? (~disp_acc + 6'd1) : disp_acc;
   end

   always_ff @(posedge pixclk or negedge reset_n) begin
      if (!reset_n) begin
         disp_acc <= '0;
         disp_err <= 1'b0;
      end else if (a_valid) begin
         if (tok) begin
            disp_acc <= '0;
            disp_err <= 1'b0;
         end else begin
            disp_acc <= disp_next;
            if (locked && (disp_mag > 6'(DISP_LIMIT))) begin
               disp_err <= 1'b1;
            end
         end
      end
   end
`else
   assign disp_err = 1'b0;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: lock acquisition, decode, loss, timeouts, reset.
// Also exercises the TMDS_DISP_MON_EN build when that macro is defined.
module tb_tmds_channel_decoder;
   import tmds_pkg::*;

   localparam int CTRL_RUN    = 8;
   localparam int SEARCH_WAIT = 1024;
   localparam int LOSS_WAIT   = 2048;
   localparam logic [9:0] TOK00 = 10'b1101010100;

   logic       pixclk = 1'b0;
   logic       reset_n;
   logic [9:0] din;
   logic [7:0] vd;
   logic [1:0] cd;
   logic       vde;
   logic       locked;
   logic [3:0] offset;
   logic       disp_err;

   int         errors = 0;
   int         checks = 0;
   int         slip   = 0;
   logic [9:0] prev_w = TOK00;

   tmds_channel_decoder #(
      .CTRL_RUN    (CTRL_RUN),
      .SEARCH_WAIT (SEARCH_WAIT),
      .LOSS_WAIT   (LOSS_WAIT),
      .DISP_LIMIT  (8)
   ) dut (
      .pixclk   (pixclk),
      .reset_n  (reset_n),
      .din      (din),
      .vd       (vd),
      .cd       (cd),
      .vde      (vde),
      .locked   (locked),
      .offset   (offset),
      .disp_err (disp_err)
   );

   always #5 pixclk = ~pixclk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Emulates the deserializer: words land in din shifted by 'slip' bits.
   task automatic send_word(input logic [9:0] w);
      logic [19:0] tmp;
      tmp    = {w, prev_w} >> (10 - slip);
      din    = tmp[9:0];
      prev_w = w;
      @(posedge pixclk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      din     = '0;
      repeat (3) @(posedge pixclk);
      #1;
      checks++; if (vd !== 8'h00)     begin errors++; $display("[TB] FAIL reset_vd: got %h expected 00", vd); end
      checks++; if (cd !== 2'b00)     begin errors++; $display("[TB] FAIL reset_cd: got %b expected 00", cd); end
      checks++; if (vde !== 1'b0)     begin errors++; $display("[TB] FAIL reset_vde: got %b expected 0", vde); end
      checks++; if (locked !== 1'b0)  begin errors++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
      checks++; if (offset !== 4'd0)  begin errors++; $display("[TB] FAIL reset_offset: got %0d expected 0", offset); end
      checks++; if (disp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_disp_err: got %b expected 0", disp_err); end
      checks++; if (dut.state !== SEARCH) begin errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state, SEARCH); end
      reset_n = 1'b1;
   endtask

   task automatic acquire(input string tag, input int exp_off, input int budget);
      int n;
      n = 0;
      while (locked !== 1'b1 && n < budget) begin
         send_word(TOK00);
         n++;
      end
      checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL %s_locked: got %b expected 1 after %0d words", tag, locked, n); end
      checks++; if (offset !== 4'(exp_off)) begin errors++; $display("[TB] FAIL %s_offset: got %0d expected %0d", tag, offset, exp_off); end
   endtask

   task automatic test_acquire_lock();
      slip   = 3;
      prev_w = TOK00;
      acquire("acquire", 3, 10 * SEARCH_WAIT + CTRL_RUN + 4);
   endtask

   task automatic test_back_to_back();
      logic [9:0] words   [10] = '{10'h163, 10'h100, 10'h200, 10'h30F, 10'h0F7,
                                   10'h0AB, 10'h154, 10'h100, 10'h2AB, 10'h354};
      logic       exp_vde [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [7:0] exp_vd  [10] = '{8'hA5, 8'h00, 8'hFF, 8'h10, 8'hE7, 8'hE7, 8'hE7, 8'h00, 8'h00, 8'h00};
      logic [1:0] exp_cd  [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
      for (int i = 0; i < 12; i++) begin
         send_word((i < 10) ? words[i] : TOK00);
         if (i >= 2) begin
            checks++; if (vde !== exp_vde[i-2]) begin errors++; $display("[TB] FAIL b2b_vde[%0d]: got %b expected %b", i-2, vde, exp_vde[i-2]); end
            checks++; if (vd !== exp_vd[i-2])   begin errors++; $display("[TB] FAIL b2b_vd[%0d]: got %h expected %h", i-2, vd, exp_vd[i-2]); end
            checks++; if (cd !== exp_cd[i-2])   begin errors++; $display("[TB] FAIL b2b_cd[%0d]: got %b expected %b", i-2, cd, exp_cd[i-2]); end
         end
      end
      checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL b2b_locked: got %b expected 1", locked); end
   endtask

   task automatic test_disparity();
      logic exp_err;
`ifdef TMDS_DISP_MON_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      for (int i = 0; i < 22; i++) send_word(10'h100);
      checks++; if (disp_err !== exp_err) begin errors++; $display("[TB] FAIL disp_err_set: got %b expected %b", disp_err, exp_err); end
      for (int i = 0; i < 4; i++) send_word(TOK00);
      checks++; if (disp_err !== 1'b0) begin errors++; $display("[TB] FAIL disp_err_clear: got %b expected 0", disp_err); end
   endtask

   task automatic test_loss_of_lock();
      int drop_at;
      drop_at = 0;
      for (int n = 1; n <= LOSS_WAIT + 10; n++) begin
         send_word(10'h100);
         if (locked === 1'b0) begin
            drop_at = n;
            break;
         end
      end
      checks++; if (drop_at !== LOSS_WAIT + 2) begin errors++; $display("[TB] FAIL loss_timing: got drop at word %0d expected %0d", drop_at, LOSS_WAIT + 2); end
      checks++; if (offset !== 4'd3) begin errors++; $display("[TB] FAIL loss_offset: got %0d expected 3", offset); end
      checks++; if (dut.state !== SEARCH) begin errors++; $display("[TB] FAIL loss_state: got %0d expected %0d", dut.state, SEARCH); end
   endtask

   task automatic test_timeout_tie();
      for (int i = 0; i < SEARCH_WAIT - 3; i++) send_word(10'h100);
      send_word(TOK00);
      send_word(10'h100);
      send_word(10'h100);
      checks++; if (dut.state !== VERIFY) begin errors++; $display("[TB] FAIL tie_state: got %0d expected %0d", dut.state, VERIFY); end
      checks++; if (offset !== 4'd3) begin errors++; $display("[TB] FAIL tie_offset: got %0d expected 3", offset); end
   endtask

   task automatic test_relock_timing();
      for (int k = 1; k <= 12; k++) begin
         send_word(TOK00);
         if (k == 9) begin
            checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL relock_early: got %b expected 0", locked); end
         end
         if (k == 10) begin
            checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL relock_edge: got %b expected 1", locked); end
         end
      end
      checks++; if (offset !== 4'd3) begin errors++; $display("[TB] FAIL relock_offset: got %0d expected 3", offset); end
   endtask

   task automatic test_reset_midop();
      send_word(10'h163);
      send_word(10'h2AB);
      send_word(TOK00);
      send_word(TOK00);
      #3 reset_n = 1'b0;
      #1;
      checks++; if (vd !== 8'h00)      begin errors++; $display("[TB] FAIL midrst_vd: got %h expected 00", vd); end
      checks++; if (cd !== 2'b00)      begin errors++; $display("[TB] FAIL midrst_cd: got %b expected 00", cd); end
      checks++; if (vde !== 1'b0)      begin errors++; $display("[TB] FAIL midrst_vde: got %b expected 0", vde); end
      checks++; if (locked !== 1'b0)   begin errors++; $display("[TB] FAIL midrst_locked: got %b expected 0", locked); end
      checks++; if (offset !== 4'd0)   begin errors++; $display("[TB] FAIL midrst_offset: got %0d expected 0", offset); end
      checks++; if (disp_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_disp_err: got %b expected 0", disp_err); end
      #1 reset_n = 1'b1;
      slip   = 0;
      prev_w = TOK00;
      acquire("midrst_relock", 0, CTRL_RUN + 8);
   endtask

   task automatic test_random_slip();
      for (int t = 0; t < 2; t++) begin
         reset_n = 1'b0;
         slip    = int'($urandom_range(0, 9));
         prev_w  = TOK00;
         send_word(TOK00);
         send_word(TOK00);
         reset_n = 1'b1;
         $display("[TB] random slip trial %0d uses slip %0d", t, slip);
         acquire("random_slip", slip, 10 * SEARCH_WAIT + CTRL_RUN + 4);
      end
   endtask

   initial begin
      test_reset();
      test_acquire_lock();
      test_back_to_back();
      test_disparity();
      test_loss_of_lock();
      test_timeout_tie();
      test_relock_timing();
      test_reset_midop();
      test_random_slip();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
